// File: rtl/hz_pkg.sv
// hz_pkg: shared types for the pipeline hazard controller.
//   op_class_t : instruction class presented by the D stage
//   fwd_sel_t  : operand source selected for the D-to-E transfer
//   hz_state_t : controller state, also exported on state_o
package hz_pkg;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_MUL    = 3'd4,
    OP_DIV    = 3'd5
  } op_class_t;

  typedef enum logic [2:0] {
    FWD_RF = 3'd0,
    FWD_E  = 3'd1,
    FWD_M  = 3'd2,
    FWD_W  = 3'd3,
    FWD_LC = 3'd4
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RESET   = 2'd0,
    HZ_WAIT    = 2'd1,
    HZ_RUNNING = 2'd2,
    HZ_DRAIN   = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: per-register busy bits for the single long-op (MUL/DIV)
// unit, its latency counter and the completion strobe.
// Ports:
//   clk, rst                      clock, async active-high reset
//   d_rs1/d_rs2, *_used           D-stage sources and their read flags
//   d_rd, d_we, d_cls             D-stage destination, write flag, class
//   issue                         D-to-E transfer happens at this edge
//   raw_stall/waw_stall/struct_stall  hazard queries for the D stage
//   lc_done, lc_rd                long-op result valid this cycle, its rd
//   lc_busy                       long-op unit occupied
//   sb_empty                      no busy bit set
module hz_scoreboard
  import hz_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] d_rs1,
  input  logic [RA_W-1:0] d_rs2,
  input  logic            d_rs1_used,
  input  logic            d_rs2_used,
  input  logic [RA_W-1:0] d_rd,
  input  logic            d_we,
  input  logic [2:0]      d_cls,
  input  logic            issue,
  output logic            raw_stall,
  output logic            waw_stall,
  output logic            struct_stall,
  output logic            lc_done,
  output logic [RA_W-1:0] lc_rd,
  output logic            lc_busy,
  output logic            sb_empty
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_clr_s;
  logic [NREGS-1:0] busy_set_s;
  logic [CNT_W-1:0] cnt_r;
  logic [RA_W-1:0]  lc_rd_r;
  logic [CNT_W-1:0] lat_s;
  logic             is_long_s;
  logic             issue_long_s;

  // A source waits on the scoreboard unless the long op is delivering it now.
  function automatic logic src_pending(input logic [RA_W-1:0]  rs,
                                       input logic             used,
                                       input logic [NREGS-1:0] busy,
                                       input logic             done,
                                       input logic [RA_W-1:0]  done_rd);
    return used && (rs != '0) && busy[rs] && !(done && (done_rd == rs));
  endfunction

  // Classify the D instruction; a DIV with no divider behaves as an ALU op.
  always_comb begin
    is_long_s = 1'b0;
    lat_s     = CNT_W'(MUL_LAT);
    case (op_class_t'(d_cls))
      OP_MUL: begin
        is_long_s = 1'b1;
        lat_s     = CNT_W'(MUL_LAT);
      end
      OP_DIV: begin
        is_long_s = (DIV_LAT > 0) ? 1'b1 : 1'b0;
        lat_s     = CNT_W'(DIV_LAT);
      end
      default: begin
        is_long_s = 1'b0;
        lat_s     = CNT_W'(MUL_LAT);
      end
    endcase
  end

  assign issue_long_s = issue && is_long_s && d_we;
  assign lc_busy      = (cnt_r != '0);
  assign lc_done      = (cnt_r == CNT_W'(1));
  assign lc_rd        = lc_rd_r;
  assign sb_empty     = (busy_r == '0);

  assign raw_stall = src_pending(d_rs1, d_rs1_used, busy_r, lc_done, lc_rd_r) ||
                     src_pending(d_rs2, d_rs2_used, busy_r, lc_done, lc_rd_r);
  assign waw_stall = d_we && (d_rd != '0) && busy_r[d_rd];
  // The last cycle of an op frees the unit, so a new op may issue into it.
  assign struct_stall = is_long_s && lc_busy && !lc_done;

  // Completion clears the old bit first, so same-cycle reissue keeps the new one.
  assign busy_clr_s = lc_done ? (NREGS'(1'b1) << lc_rd_r) : '0;
  assign busy_set_s = (issue_long_s && (d_rd != '0)) ? (NREGS'(1'b1) << d_rd) : '0;

  // Busy vector update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~busy_clr_s) | busy_set_s;
    end
  end

  // Latency counter runs freely once loaded; it ignores pipeline stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      lc_rd_r <= '0;
    end else if (issue_long_s) begin
      cnt_r   <= lat_s;
      lc_rd_r <= d_rd;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush and forwarding control for the
// five-stage F/D/E/M/W pipeline, with long-op scoreboard and drain mode.
// Ports:
//   clk, rst                          clock, async active-high reset
//   instr_ready, data_ready           fetch / data memory response valid
//   d_* / e_* / m_* / w_*             per-stage register use and validity
//   branch_taken                      taken redirect resolved in E
//   drain_req                         level request to empty the pipeline
//   read_instr                        fetch enable
//   stall_f/d/e/m, flush_f/d/e        stage-register hold / bubble controls
//   fwd1, fwd2                        operand sources (fwd_sel_t)
//   lc_done, lc_rd                    long-op completion and its rd
//   drain_ack                         single pulse once the pipeline is empty
//   state_o                           current hz_state_t
module pipeline_hazard_ctrl
  import hz_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_ready,
  input  logic            data_ready,
  input  logic            d_valid,
  input  logic [RA_W-1:0] d_rs1,
  input  logic [RA_W-1:0] d_rs2,
  input  logic            d_rs1_used,
  input  logic            d_rs2_used,
  input  logic [RA_W-1:0] d_rd,
  input  logic            d_we,
  input  logic [2:0]      d_cls,
  input  logic            e_valid,
  input  logic            e_we,
  input  logic            e_is_load,
  input  logic [RA_W-1:0] e_rd,
  input  logic            m_valid,
  input  logic            m_we,
  input  logic            m_is_load,
  input  logic [RA_W-1:0] m_rd,
  input  logic            w_we,
  input  logic [RA_W-1:0] w_rd,
  input  logic            branch_taken,
  input  logic            drain_req,
  output logic            read_instr,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            stall_m,
  output logic            flush_f,
  output logic            flush_d,
  output logic            flush_e,
  output logic [2:0]      fwd1,
  output logic [2:0]      fwd2,
  output logic            lc_done,
  output logic [RA_W-1:0] lc_rd,
  output logic            drain_ack,
  output logic [1:0]      state_o
);

  hz_state_t state_r;
  hz_state_t state_nx_s;
  logic      drain_done_r;
  logic      mem_wait_s;
  logic      load_use_s;
  logic      hazard_stall_s;
  logic      pipe_empty_s;
  logic      issue_s;
  logic      raw_s;
  logic      waw_s;
  logic      struct_s;
  logic      lc_busy_s;
  logic      sb_empty_s;
  logic      unused_s;

  // Fetch-valid is handled by the fetch stage; the controller does not gate on it.
  assign unused_s = instr_ready;

  function automatic fwd_sel_t pick_fwd(input logic [RA_W-1:0] rs,
                                        input logic            used,
                                        input logic            e_hit_en,
                                        input logic [RA_W-1:0] erd,
                                        input logic            m_hit_en,
                                        input logic [RA_W-1:0] mrd,
                                        input logic            lc_hit_en,
                                        input logic [RA_W-1:0] lcrd,
                                        input logic            w_hit_en,
                                        input logic [RA_W-1:0] wrd);
    if (!used || (rs == '0))           return FWD_RF;
    else if (e_hit_en && (erd == rs))  return FWD_E;
    else if (m_hit_en && (mrd == rs))  return FWD_M;
    else if (lc_hit_en && (lcrd == rs)) return FWD_LC;
    else if (w_hit_en && (wrd == rs))  return FWD_W;
    else                               return FWD_RF;
  endfunction

  hz_scoreboard #(
    .NREGS  (NREGS),
    .RA_W   (RA_W),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .d_rs1       (d_rs1),
    .d_rs2       (d_rs2),
    .d_rs1_used  (d_rs1_used),
    .d_rs2_used  (d_rs2_used),
    .d_rd        (d_rd),
    .d_we        (d_we),
    .d_cls       (d_cls),
    .issue       (issue_s),
    .raw_stall   (raw_s),
    .waw_stall   (waw_s),
    .struct_stall(struct_s),
    .lc_done     (lc_done),
    .lc_rd       (lc_rd),
    .lc_busy     (lc_busy_s),
    .sb_empty    (sb_empty_s)
  );

  assign mem_wait_s = !data_ready && ((e_is_load && e_valid) || (m_is_load && m_valid));

  assign load_use_s = e_valid && e_we && e_is_load && (e_rd != '0) &&
                      ((d_rs1_used && (d_rs1 == e_rd)) || (d_rs2_used && (d_rs2 == e_rd)));

  assign hazard_stall_s = d_valid && (load_use_s || raw_s || waw_s || struct_s);
  assign pipe_empty_s   = !e_valid && !m_valid && !w_we && sb_empty_s && !lc_busy_s;
  assign issue_s        = d_valid && !stall_d && !flush_d;

  // A load still in E is not forwardable; its consumer is held by load-use.
  assign fwd1 = pick_fwd(d_rs1, d_rs1_used, e_valid && e_we && !e_is_load, e_rd,
                         m_valid && m_we, m_rd, lc_done, lc_rd, w_we, w_rd);
  assign fwd2 = pick_fwd(d_rs2, d_rs2_used, e_valid && e_we && !e_is_load, e_rd,
                         m_valid && m_we, m_rd, lc_done, lc_rd, w_we, w_rd);

  assign state_o = state_r;

  // State register and one-shot drain acknowledge memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= HZ_RESET;
      drain_done_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (state_r != HZ_DRAIN) begin
        drain_done_r <= 1'b0;
      end else if (drain_ack) begin
        drain_done_r <= 1'b1;
      end else begin
        drain_done_r <= drain_done_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      HZ_RESET:   state_nx_s = HZ_WAIT;
      HZ_WAIT:    state_nx_s = HZ_RUNNING;
      HZ_RUNNING: state_nx_s = drain_req ? HZ_DRAIN : HZ_RUNNING;
      HZ_DRAIN: begin
        if (!drain_req && (drain_done_r || drain_ack)) begin
          state_nx_s = HZ_RUNNING;
        end else begin
          state_nx_s = HZ_DRAIN;
        end
      end
      default:    state_nx_s = HZ_RESET;
    endcase
  end

  // Stall/flush/fetch outputs; mem_wait dominates, then redirect, then D hazards.
  always_comb begin
    read_instr = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_f    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    drain_ack  = 1'b0;
    case (state_r)
      HZ_RESET: begin
        flush_f = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      HZ_WAIT: begin
        read_instr = 1'b1;
        flush_f    = 1'b1;
        flush_d    = 1'b1;
        flush_e    = 1'b1;
      end
      HZ_RUNNING: begin
        if (mem_wait_s) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
        end else if (branch_taken) begin
          flush_f = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (hazard_stall_s) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else begin
          stall_f = 1'b0;
        end
        read_instr = !stall_f;
      end
      HZ_DRAIN: begin
        flush_f   = 1'b1;
        flush_d   = 1'b1;
        stall_e   = mem_wait_s;
        stall_m   = mem_wait_s;
        drain_ack = pipe_empty_s && !drain_done_r;
      end
      default: begin
        flush_f = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (default parameters: MUL_LAT=3,
// DIV_LAT=16). Inputs change just after each falling edge and outputs are
// sampled 2 time units later, well before the next rising edge.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_ready, data_ready;
  logic       d_valid, d_rs1_used, d_rs2_used, d_we;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic [2:0] d_cls;
  logic       e_valid, e_we, e_is_load;
  logic [4:0] e_rd;
  logic       m_valid, m_we, m_is_load;
  logic [4:0] m_rd;
  logic       w_we;
  logic [4:0] w_rd;
  logic       branch_taken, drain_req;
  logic       read_instr, stall_f, stall_d, stall_e, stall_m;
  logic       flush_f, flush_d, flush_e;
  logic [2:0] fwd1, fwd2;
  logic       lc_done;
  logic [4:0] lc_rd;
  logic       drain_ack;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .instr_ready(instr_ready), .data_ready(data_ready),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs1_used(d_rs1_used),
    .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_we(d_we), .d_cls(d_cls),
    .e_valid(e_valid), .e_we(e_we), .e_is_load(e_is_load), .e_rd(e_rd),
    .m_valid(m_valid), .m_we(m_we), .m_is_load(m_is_load), .m_rd(m_rd),
    .w_we(w_we), .w_rd(w_rd), .branch_taken(branch_taken), .drain_req(drain_req),
    .read_instr(read_instr), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .flush_f(flush_f), .flush_d(flush_d), .flush_e(flush_e),
    .fwd1(fwd1), .fwd2(fwd2), .lc_done(lc_done), .lc_rd(lc_rd),
    .drain_ack(drain_ack), .state_o(state_o)
  );

  task automatic idle();
    instr_ready = 1'b1; data_ready = 1'b1;
    d_valid = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_rs1_used = 1'b0; d_rs2_used = 1'b0;
    d_rd = 5'd0; d_we = 1'b0; d_cls = 3'd0;
    e_valid = 1'b0; e_we = 1'b0; e_is_load = 1'b0; e_rd = 5'd0;
    m_valid = 1'b0; m_we = 1'b0; m_is_load = 1'b0; m_rd = 5'd0;
    w_we = 1'b0; w_rd = 5'd0; branch_taken = 1'b0; drain_req = 1'b0;
  endtask

  // D-stage MUL writing rd
  task automatic put_mul(input logic [4:0] rd);
    d_valid = 1'b1; d_cls = 3'd4; d_we = 1'b1; d_rd = rd;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state_o); end
    checks++; if (read_instr !== 1'b0) begin errors++; $display("FAIL rst_read: got %b want 0", read_instr); end
    checks++; if ({flush_f, flush_d, flush_e} !== 3'b111) begin errors++; $display("FAIL rst_flush: got %b want 111", {flush_f, flush_d, flush_e}); end
    checks++; if ({lc_done, drain_ack} !== 2'b00) begin errors++; $display("FAIL rst_lc_ack: got %b want 00", {lc_done, drain_ack}); end
    @(negedge clk); rst = 1'b0; #2;
    checks++; if (state_o !== 2'd0 || read_instr !== 1'b0) begin errors++; $display("FAIL rel_reset: state %0d read %b want 0 0", state_o, read_instr); end
    @(negedge clk); #2;
    checks++; if (state_o !== 2'd1 || read_instr !== 1'b1) begin errors++; $display("FAIL rel_wait: state %0d read %b want 1 1", state_o, read_instr); end
    checks++; if ({flush_f, flush_d, flush_e} !== 3'b111) begin errors++; $display("FAIL wait_flush: got %b want 111", {flush_f, flush_d, flush_e}); end
    @(negedge clk); #2;
    checks++; if (state_o !== 2'd2 || read_instr !== 1'b1) begin errors++; $display("FAIL rel_run: state %0d read %b want 2 1", state_o, read_instr); end
    checks++; if ({flush_f, flush_d, flush_e} !== 3'b000) begin errors++; $display("FAIL run_flush: got %b want 000", {flush_f, flush_d, flush_e}); end
  endtask

  task automatic test_forward();
    @(negedge clk); idle();
    e_valid = 1'b1; e_we = 1'b1; e_rd = 5'd5;
    d_valid = 1'b1; d_rs1 = 5'd5; d_rs1_used = 1'b1; d_we = 1'b1; d_rd = 5'd6; #2;
    checks++; if (fwd1 !== 3'd1) begin errors++; $display("FAIL fwd_e: got %0d want 1", fwd1); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL fwd_e_stall: got %b want 0", stall_d); end
    @(negedge clk); e_rd = 5'd0; d_rs1 = 5'd0; #2;
    checks++; if (fwd1 !== 3'd0) begin errors++; $display("FAIL fwd_x0: got %0d want 0", fwd1); end
    @(negedge clk); idle();
    m_valid = 1'b1; m_we = 1'b1; m_rd = 5'd5; w_we = 1'b1; w_rd = 5'd5;
    d_valid = 1'b1; d_rs2 = 5'd5; d_rs2_used = 1'b1; #2;
    checks++; if (fwd2 !== 3'd2) begin errors++; $display("FAIL fwd_m_over_w: got %0d want 2", fwd2); end
    @(negedge clk); m_valid = 1'b0; w_rd = 5'd9; d_rs2 = 5'd9; #2;
    checks++; if (fwd2 !== 3'd3) begin errors++; $display("FAIL fwd_w: got %0d want 3", fwd2); end
    @(negedge clk); d_rs2_used = 1'b0; #2;
    checks++; if (fwd2 !== 3'd0) begin errors++; $display("FAIL fwd_unused: got %0d want 0", fwd2); end
  endtask

  task automatic test_load_use();
    @(negedge clk); idle();
    e_valid = 1'b1; e_we = 1'b1; e_is_load = 1'b1; e_rd = 5'd3;
    d_valid = 1'b1; d_rs1 = 5'd3; d_rs1_used = 1'b1; #2;
    checks++; if ({stall_f, stall_d, flush_e, stall_e} !== 4'b1110) begin errors++; $display("FAIL lu_stall: got %b want 1110", {stall_f, stall_d, flush_e, stall_e}); end
    checks++; if (read_instr !== 1'b0 || fwd1 !== 3'd0) begin errors++; $display("FAIL lu_read_fwd: read %b fwd %0d want 0 0", read_instr, fwd1); end
    @(negedge clk); e_valid = 1'b0; e_we = 1'b0; e_is_load = 1'b0;
    m_valid = 1'b1; m_we = 1'b1; m_is_load = 1'b1; m_rd = 5'd3; #2;
    checks++; if (stall_d !== 1'b0 || fwd1 !== 3'd2) begin errors++; $display("FAIL lu_after: stall %b fwd %0d want 0 2", stall_d, fwd1); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); data_ready = 1'b0; #2;
      checks++; if ({stall_f, stall_d, stall_e, stall_m, flush_e} !== 5'b11110) begin errors++; $display("FAIL memwait_%0d: got %b want 11110", i, {stall_f, stall_d, stall_e, stall_m, flush_e}); end
    end
    @(negedge clk); data_ready = 1'b1; #2;
    checks++; if ({stall_f, stall_d, stall_e, stall_m} !== 4'b0000) begin errors++; $display("FAIL memwait_end: got %b want 0000", {stall_f, stall_d, stall_e, stall_m}); end
  endtask

  task automatic test_mul();
    @(negedge clk); idle(); put_mul(5'd7); #2;
    checks++; if (stall_d !== 1'b0 || lc_done !== 1'b0) begin errors++; $display("FAIL mul_issue: stall %b done %b want 0 0", stall_d, lc_done); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle();
      d_valid = 1'b1; d_rs1 = 5'd7; d_rs1_used = 1'b1; d_we = 1'b1; d_rd = 5'd8; #2;
      checks++; if ({stall_d, stall_f, flush_e, lc_done} !== 4'b1110) begin errors++; $display("FAIL mul_raw_%0d: got %b want 1110", i, {stall_d, stall_f, flush_e, lc_done}); end
    end
    @(negedge clk); #2;
    checks++; if (lc_done !== 1'b1 || lc_rd !== 5'd7) begin errors++; $display("FAIL mul_done: done %b rd %0d want 1 7", lc_done, lc_rd); end
    checks++; if (stall_d !== 1'b0 || fwd1 !== 3'd4) begin errors++; $display("FAIL mul_fwd_lc: stall %b fwd %0d want 0 4", stall_d, fwd1); end
    @(negedge clk); idle(); #2;
    checks++; if (lc_done !== 1'b0) begin errors++; $display("FAIL mul_done_clr: got %b want 0", lc_done); end
    // structural: second MUL waits until the counter reaches 1
    @(negedge clk); put_mul(5'd7); #2;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL mul2_first: got %b want 0", stall_d); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); put_mul(5'd9); #2;
      checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL mul2_struct_%0d: got %b want 1", i, stall_d); end
    end
    @(negedge clk); #2;
    checks++; if (stall_d !== 1'b0 || lc_done !== 1'b1 || lc_rd !== 5'd7) begin errors++; $display("FAIL mul2_reissue: stall %b done %b rd %0d want 0 1 7", stall_d, lc_done, lc_rd); end
    @(negedge clk); idle(); d_valid = 1'b1; d_we = 1'b1; d_rd = 5'd9; #2;
    checks++; if (stall_d !== 1'b1 || lc_done !== 1'b0) begin errors++; $display("FAIL waw: stall %b done %b want 1 0", stall_d, lc_done); end
    @(negedge clk); idle();
    @(negedge clk); #2;
    checks++; if (lc_done !== 1'b1 || lc_rd !== 5'd9) begin errors++; $display("FAIL mul2_done: done %b rd %0d want 1 9", lc_done, lc_rd); end
    @(negedge clk); #2;
  endtask

  task automatic test_branch();
    @(negedge clk); idle();
    e_valid = 1'b1; e_we = 1'b1; e_is_load = 1'b1; e_rd = 5'd3;
    d_valid = 1'b1; d_rs1 = 5'd3; d_rs1_used = 1'b1; branch_taken = 1'b1; #2;
    checks++; if ({flush_f, flush_d, flush_e, stall_f, stall_d} !== 5'b11100) begin errors++; $display("FAIL br_lu: got %b want 11100", {flush_f, flush_d, flush_e, stall_f, stall_d}); end
    @(negedge clk); idle();
    m_valid = 1'b1; m_we = 1'b1; m_is_load = 1'b1; m_rd = 5'd4; data_ready = 1'b0; branch_taken = 1'b1; #2;
    checks++; if ({flush_f, flush_d, flush_e, stall_e} !== 4'b0001) begin errors++; $display("FAIL br_memwait: got %b want 0001", {flush_f, flush_d, flush_e, stall_e}); end
    @(negedge clk); data_ready = 1'b1; #2;
    checks++; if ({flush_f, flush_d, flush_e, stall_e} !== 4'b1110) begin errors++; $display("FAIL br_release: got %b want 1110", {flush_f, flush_d, flush_e, stall_e}); end
  endtask

  task automatic test_drain();
    @(negedge clk); idle(); put_mul(5'd7);
    @(negedge clk); idle(); drain_req = 1'b1; e_valid = 1'b1; #2;
    checks++; if (state_o !== 2'd2 || read_instr !== 1'b1 || drain_ack !== 1'b0) begin errors++; $display("FAIL dr_req: state %0d read %b ack %b want 2 1 0", state_o, read_instr, drain_ack); end
    @(negedge clk); #2;
    checks++; if (state_o !== 2'd3 || read_instr !== 1'b0 || {flush_f, flush_d} !== 2'b11) begin errors++; $display("FAIL dr_enter: state %0d read %b fl %b want 3 0 11", state_o, read_instr, {flush_f, flush_d}); end
    checks++; if (drain_ack !== 1'b0) begin errors++; $display("FAIL dr_ack_e: got %b want 0", drain_ack); end
    @(negedge clk); e_valid = 1'b0; m_valid = 1'b1; #2;
    checks++; if (lc_done !== 1'b1 || drain_ack !== 1'b0) begin errors++; $display("FAIL dr_lc: done %b ack %b want 1 0", lc_done, drain_ack); end
    @(negedge clk); #2;
    checks++; if (drain_ack !== 1'b0) begin errors++; $display("FAIL dr_ack_m: got %b want 0", drain_ack); end
    @(negedge clk); m_valid = 1'b0; w_we = 1'b1; w_rd = 5'd7; #2;
    checks++; if (drain_ack !== 1'b0) begin errors++; $display("FAIL dr_ack_w: got %b want 0", drain_ack); end
    @(negedge clk); w_we = 1'b0; #2;
    checks++; if (drain_ack !== 1'b1) begin errors++; $display("FAIL dr_ack_pulse: got %b want 1", drain_ack); end
    @(negedge clk); #2;
    checks++; if (drain_ack !== 1'b0 || state_o !== 2'd3) begin errors++; $display("FAIL dr_ack_once: ack %b state %0d want 0 3", drain_ack, state_o); end
    @(negedge clk); drain_req = 1'b0; #2;
    checks++; if (drain_ack !== 1'b0 || state_o !== 2'd3) begin errors++; $display("FAIL dr_release: ack %b state %0d want 0 3", drain_ack, state_o); end
    @(negedge clk); #2;
    checks++; if (state_o !== 2'd2 || read_instr !== 1'b1) begin errors++; $display("FAIL dr_exit: state %0d read %b want 2 1", state_o, read_instr); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk); idle(); put_mul(5'd7);
    @(negedge clk); idle(); rst = 1'b1; #2;
    checks++; if (state_o !== 2'd0 || lc_done !== 1'b0) begin errors++; $display("FAIL rmid_rst: state %0d done %b want 0 0", state_o, lc_done); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #2;
    checks++; if (state_o !== 2'd1 || lc_done !== 1'b0) begin errors++; $display("FAIL rmid_nodone: state %0d done %b want 1 0", state_o, lc_done); end
    @(negedge clk); d_valid = 1'b1; d_rs1 = 5'd7; d_rs1_used = 1'b1; #2;
    checks++; if (state_o !== 2'd2 || stall_d !== 1'b0) begin errors++; $display("FAIL rmid_busy: state %0d stall %b want 2 0", state_o, stall_d); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_forward();
    test_load_use();
    test_mul();
    test_branch();
    test_drain();
    test_reset_mid_op();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard, stall, flush and forwarding controller for the 5-stage RV32 pipeline (F, D, E, M, W). It replaces the ad-hoc hazard logic inside the core. New capabilities:
- a per-register scoreboard for multi-cycle MUL/DIV units of configurable latency;
- WAW and structural-hazard stalls;
- a DRAIN mode used by fences and interrupt entry.

Stall, flush and forward outputs are combinational; state, scoreboard and counters are sequential.

Parameters:
NREGS, 32, architectural register count (register 0 is hardwired zero)
RA_W, 5, register address width, equal to clog2(NREGS)
MUL_LAT, 3, cycles from MUL issue into E until result valid (1..15)
DIV_LAT, 16, cycles for DIV (0 means no divider; DIV class is treated as ALU)
CNT_W, 5, latency counter width; must hold max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr_ready  in  1  fetch data valid
data_ready  in  1  data memory response valid
d_valid  in  1  D holds a real instruction
d_rs1, d_rs2  in  RA_W each  D source registers
d_rs1_used, d_rs2_used  in  1 each  source is actually read
d_rd  in  RA_W  D destination register
d_we  in  1  D writes rd
d_cls  in  3  D class (op_class_t)
e_valid, e_we, e_is_load  in  1 each  E stage flags
e_rd  in  RA_W  E destination register
m_valid, m_we, m_is_load  in  1 each  M stage flags
m_rd  in  RA_W  M destination register
w_we  in  1  W stage write enable
w_rd  in  RA_W  W destination register
branch_taken  in  1  E resolved a taken branch or jump
drain_req  in  1  level request to empty the pipeline
read_instr  out  1  fetch enable
stall_f, stall_d, stall_e, stall_m  out  1 each  hold the stage register
flush_f, flush_d, flush_e  out  1 each  load a bubble at the next edge
fwd1, fwd2  out  3 each  operand source for D-to-E (fwd_sel_t)
lc_done  out  1  long-op result valid this cycle
lc_rd  out  RA_W  long-op destination register
drain_ack  out  1  one-cycle pulse when the pipeline is empty
state_o  out  2  current hz_state_t

Behaviour:
- Reset (async): state=RESET, scoreboard clear, counter=0, lc_done=0, lc_rd=0, drain_ack=0.
- States and transitions:
  - RESET -> WAIT after 1 cycle.
  - WAIT -> RUNNING after 1 cycle.
  - RUNNING -> DRAIN when drain_req.
  - DRAIN -> RUNNING once drain_req=0 and drain_ack has been issued.
- State outputs:
  - RESET: read_instr=0, all flushes=1.
  - WAIT: read_instr=1, all flushes=1.
  - RUNNING: read_instr = !stall_f.
  - DRAIN: read_instr=0, flush_f=flush_d=1.
- DRAIN completion: drain_ack pulses for exactly 1 cycle on the first cycle with !e_valid & !m_valid & !w_we & scoreboard empty & !lc_busy. No further pulse until DRAIN is re-entered.
- A hazard match on register r requires: r != 0, the source's used bit set, and the producer's valid and we bits set.
- Issue is the D-to-E transfer: d_valid & !stall_d & !flush_d.
- mem_wait = !data_ready & ((e_is_load & e_valid) | (m_is_load & m_valid)).
  - When mem_wait: stall_m=stall_e=stall_d=stall_f=1.
  - While mem_wait, all hazard flushes are suppressed; a branch held in E resolves after the wait ends.
- Load-use: e_is_load matching d_rs1 or d_rs2 gives stall_d=stall_f=1 and flush_e=1 (one bubble). Afterwards the value is taken from M.
- Scoreboard: busy bit per register plus a single long-op unit.
  - Issue of MUL (or DIV when DIV_LAT>0) with d_we: set busy[d_rd], lc_busy=1, counter=LAT.
  - Counter decrements every cycle regardless of stalls.
  - On counter==1: lc_done=1 and lc_rd=rd; the busy bit clears at the following edge.
- D stalls (stall_d=stall_f=1, flush_e=1) when any of:
  - RAW: a used source has its busy bit set and lc_done is not asserted for that register this cycle.
  - WAW: d_we and busy[d_rd].
  - Structural: d_cls is MUL/DIV and lc_busy, except when counter==1 (same-cycle reissue allowed).
- Control hazard: branch_taken & !mem_wait gives flush_f=flush_d=flush_e=1.
  - The redirect takes priority over load-use and scoreboard stalls in the same cycle.
  - A long op already issued is older than the branch and is never cancelled.
- Forward priority per source:
  1. FWD_E (e non-load match)
  2. FWD_M (m match, covers load data)
  3. FWD_LC (lc_done & lc_rd match)
  4. FWD_W (w match)
  5. FWD_RF
- The rd=0 source always selects FWD_RF.
- Reset asserted mid long-op discards the op; no lc_done is produced.

Decomposition:
- Package hz_pkg holds: op_class_t (ALU, LOAD, STORE, BRANCH, MUL, DIV), fwd_sel_t (FWD_RF, FWD_E, FWD_M, FWD_W, FWD_LC), hz_state_t (RESET, WAIT, RUNNING, DRAIN).
- Sub-module hz_scoreboard holds the busy vector, latency counter, lc_done/lc_rd generation and the RAW/WAW/structural query outputs.

Test Plan:
- Reset release: read_instr is 0, then 1 in WAIT, then !stall_f; flushes are high for 2 cycles; state_o sequence is 0, 1, 2.
- ADD x5 in E, D reads x5 as rs1 -> fwd1=FWD_E, no stall. Same case with x0 -> fwd1=FWD_RF.
- LW x3 in E, D uses x3 -> 1 cycle of stall_d/stall_f/flush_e; next cycle fwd=FWD_M. With data_ready=0 for 3 cycles -> all stalls held for 3 cycles.
- MUL x7 issued with MUL_LAT=3, ADD using x7 in D -> stalled 2 cycles; lc_done with lc_rd=7 on cycle 3 and fwd=FWD_LC. A second MUL arriving during the op stalls until counter==1.
- branch_taken together with a load-use hazard -> flush_f/d/e=1, no stall. branch_taken during mem_wait -> no flush until data_ready.
- drain_req with a MUL in flight (DIV_LAT=16) -> read_instr=0, drain_ack pulses exactly once after lc_done and after e/m/w empty. Deasserting drain_req returns state to RUNNING.
